// File: rtl/poly_signal_generator.sv
// poly_signal_generator: N-voice tone/noise generator with a saturating
// volume mixer that drives a 1-bit PWM audio output.
//
// Register bus: write_strobe is a single-cycle write qualifier with no
// ready/backpressure; every strobed write is accepted on the clock edge that
// samples it. address = {voice index, sub-register}:
//   sub 0 stages the period low byte, sub 1 commits {data, staged low byte}
//   as the new period in one step, sub 2 sets volume, sub 3 sets
//   {noise_mode, enable}.
`timescale 1ns/1ps
module poly_signal_generator #(
  parameter int N_VOICES  = 4,
  parameter int PERIOD_W  = 12,
  parameter int PWM_W     = 8,
  parameter int MIX_SHIFT = 2,
  parameter int VIDX_W    = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                write_strobe,
  input  logic [VIDX_W+1:0]   address,
  input  logic [7:0]          data,
  output logic                signal_out,
  output logic [PWM_W-1:0]    mix_level,
  output logic [N_VOICES-1:0] voice_wave
);

  localparam int SUM_W   = 4 + $clog2(N_VOICES);
  localparam int SHIFT_W = SUM_W + MIX_SHIFT;
  localparam int CMP_W   = (SHIFT_W > PWM_W) ? SHIFT_W : PWM_W;

  // Write decode
  logic [VIDX_W-1:0] wr_voice;
  logic [1:0]        wr_sub;
  logic              wr_valid;

  // Per-voice configuration
  logic [PERIOD_W-1:0] period     [N_VOICES];
  logic [7:0]          staged_low [N_VOICES];
  logic [3:0]          vol        [N_VOICES];
  logic [N_VOICES-1:0] en;
  logic [N_VOICES-1:0] noise_mode;

  // Per-voice oscillator state
  logic [PERIOD_W-1:0] cnt [N_VOICES];
  logic [N_VOICES-1:0] wave;
  logic [N_VOICES-1:0] dis_now;

  // Shared noise source, mixer and PWM
  logic [14:0]      lfsr;
  logic [SUM_W-1:0] sum;
  logic [CMP_W-1:0] shifted;
  logic [PWM_W-1:0] mix_next;
  logic [PWM_W-1:0] pwm_cnt;
  logic [PWM_W-1:0] duty;

  assign wr_voice   = address[VIDX_W+1:2];
  assign wr_sub     = address[1:0];
  // Voice indices beyond the implemented voices are silently dropped.
  assign wr_valid   = write_strobe && (int'(wr_voice) < N_VOICES);
  assign voice_wave = wave;

  // Per-voice flag for a write that clears enable this cycle; it must beat a
  // coincident toggle so the voice goes silent immediately.
  always_comb begin
    dis_now = '0;
    for (int v = 0; v < N_VOICES; v++) begin
      dis_now[v] = wr_valid && (wr_voice == VIDX_W'(v)) &&
                   (wr_sub == 2'd3) && !data[0];
    end
  end

  // Register file: staged low byte, atomic period commit, volume, enable/mode.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int v = 0; v < N_VOICES; v++) begin
        period[v]     <= '0;
        staged_low[v] <= '0;
        vol[v]        <= '0;
      end
      en         <= '0;
      noise_mode <= '0;
    end else if (wr_valid) begin
      for (int v = 0; v < N_VOICES; v++) begin
        if (wr_voice == VIDX_W'(v)) begin
          case (wr_sub)
            2'd0: staged_low[v] <= data;
            2'd1: period[v]     <= {data[PERIOD_W-9:0], staged_low[v]};
            2'd2: vol[v]        <= data[3:0];
            2'd3: begin
              en[v]         <= data[0];
              noise_mode[v] <= data[1];
            end
            default: ;
          endcase
        end
      end
    end
  end

  // Voice oscillators: count to period, then wrap and toggle (tone) or
  // resample the LFSR (noise). >= lets a lowered period wrap right away.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int v = 0; v < N_VOICES; v++) begin
        cnt[v] <= '0;
      end
      wave <= '0;
    end else begin
      for (int v = 0; v < N_VOICES; v++) begin
        if (!en[v] || (period[v] == '0) || dis_now[v]) begin
          cnt[v]  <= '0;
          wave[v] <= 1'b0;
        end else if (cnt[v] >= period[v]) begin
          cnt[v]  <= '0;
          wave[v] <= noise_mode[v] ? lfsr[0] : ~wave[v];
        end else begin
          cnt[v] <= cnt[v] + PERIOD_W'(1);
        end
      end
    end
  end

  // Shared 15-bit Fibonacci LFSR (x^15 + x^14 + 1), advancing every cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr <= 15'h0001;
    end else begin
      lfsr <= {lfsr[13:0], lfsr[14] ^ lfsr[13]};
    end
  end

  // Mixer sum: gated volumes, scaled, then clipped to the PWM range.
  always_comb begin
    sum = '0;
    for (int v = 0; v < N_VOICES; v++) begin
      sum = sum + (wave[v] ? SUM_W'(vol[v]) : SUM_W'(0));
    end
    shifted = CMP_W'(sum) << MIX_SHIFT;
    if (shifted > CMP_W'({PWM_W{1'b1}})) begin
      mix_next = '1;
    end else begin
      mix_next = shifted[PWM_W-1:0];
    end
  end

  // Registered mix level.
  always_ff @(posedge clk) begin
    if (rst) begin
      mix_level <= '0;
    end else begin
      mix_level <= mix_next;
    end
  end

  // PWM: duty only changes at the end of a PWM period so no period is cut.
  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_cnt    <= '0;
      duty       <= '0;
      signal_out <= 1'b0;
    end else begin
      pwm_cnt    <= pwm_cnt + PWM_W'(1);
      signal_out <= (pwm_cnt < duty);
      if (pwm_cnt == '1) begin
        duty <= mix_level;
      end
    end
  end

endmodule

// File: tb/tb_poly_signal_generator.sv
// Testbench for poly_signal_generator: directed register writes, a mix_level
// scoreboard fed by the stimulus, and direct checks of timing and PWM output.
`timescale 1ns/1ps
module tb_poly_signal_generator;

  localparam int ADDR_W = 5;

  // ---------------- clock / reset ----------------
  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             write_strobe = 1'b0;
  logic [ADDR_W-1:0] address = '0;
  logic [7:0]       data = '0;
  logic             signal_out, sat_signal_out;
  logic [7:0]       mix_level, sat_mix_level;
  logic [3:0]       voice_wave, sat_voice_wave;

  always #5 clk = ~clk;

  poly_signal_generator #(
    .N_VOICES(4), .PERIOD_W(12), .PWM_W(8), .MIX_SHIFT(2), .VIDX_W(3)
  ) dut (
    .clk(clk), .rst(rst), .write_strobe(write_strobe), .address(address),
    .data(data), .signal_out(signal_out), .mix_level(mix_level),
    .voice_wave(voice_wave)
  );

  poly_signal_generator #(
    .N_VOICES(4), .PERIOD_W(12), .PWM_W(8), .MIX_SHIFT(3), .VIDX_W(3)
  ) dut_sat (
    .clk(clk), .rst(rst), .write_strobe(write_strobe), .address(address),
    .data(data), .signal_out(sat_signal_out), .mix_level(sat_mix_level),
    .voice_wave(sat_voice_wave)
  );

  // Reference noise source for noise-mode checks.
  logic [14:0] m_lfsr;
  always @(posedge clk) begin
    if (rst) m_lfsr <= 15'h0001;
    else     m_lfsr <= {m_lfsr[13:0], m_lfsr[14] ^ m_lfsr[13]};
  end

  // ---------------- scoreboard ----------------
  int n_cmp  = 0;
  int n_fail = 0;
  logic [7:0] exp_q[$];
  logic       mon_en = 1'b0;
  logic [7:0] mix_prev = '0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: each change of mix_level pops one expected value.
  always @(negedge clk) begin
    if (mon_en && (mix_level !== mix_prev)) begin
      if (exp_q.size() == 0) begin
        check("mix_unexpected_change", 32'(mix_level), 32'(mix_prev));
      end else begin
        check("mix_level_seq", 32'(mix_level), 32'(exp_q.pop_front()));
      end
    end
    mix_prev = mix_level;
  end

  // ---------------- driver tasks ----------------
  task automatic wr(input int v, input int sub, input int d);
    write_strobe = 1'b1;
    address      = ADDR_W'((v << 2) | sub);
    data         = 8'(d);
    @(posedge clk);
    #1;
    write_strobe = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wave0_interval(input string name);
    logic prev;
    int   n;
    prev = voice_wave[0];
    n = 0;
    do begin @(negedge clk); n++; end while (voice_wave[0] == prev && n < 100);
    prev = voice_wave[0];
    n = 0;
    do begin @(negedge clk); n++; end while (voice_wave[0] == prev && n < 100);
    check(name, 32'(n), 32'd4);
  endtask

  task automatic count_high(input logic sel_sat, output int hi);
    hi = 0;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      if ((sel_sat ? sat_signal_out : signal_out) === 1'b1) hi++;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int   n, hi;
    logic pv, pre, exp_wave, any_high;

    // Reset held 3 cycles with random writes that must be ignored.
    rst = 1'b1;
    write_strobe = 1'b1;
    for (int i = 0; i < 3; i++) begin
      address = ADDR_W'($urandom_range(0, 31));
      data    = 8'($urandom_range(0, 255));
      @(posedge clk);
    end
    @(negedge clk);
    check("rst_signal_out", 32'(signal_out), 0);
    check("rst_mix_level", 32'(mix_level), 0);
    check("rst_voice_wave", 32'(voice_wave), 0);
    check("rst_lfsr", 32'(dut.lfsr), 32'h1);
    check("rst_en", 32'(dut.en), 0);
    check("rst_pwm_cnt", 32'(dut.pwm_cnt), 0);
    for (int v = 0; v < 4; v++) begin
      check("rst_period", 32'(dut.period[v]), 0);
      check("rst_vol", 32'(dut.vol[v]), 0);
      check("rst_staged", 32'(dut.staged_low[v]), 0);
    end
    rst = 1'b0;
    write_strobe = 1'b0;
    @(negedge clk);
    check("lfsr_first", 32'(dut.lfsr), 32'h2);
    @(negedge clk);
    check("lfsr_second", 32'(dut.lfsr), 32'h4);

    // Out-of-range voice 5 must not touch any voice.
    wr(5, 0, 8'h07);
    wr(5, 1, 8'h00);
    wr(5, 2, 8'h0F);
    wr(5, 3, 8'h01);
    repeat (20) @(negedge clk);
    check("v5_voice_wave", 32'(voice_wave), 0);
    check("v5_mix_level", 32'(mix_level), 0);
    check("v5_en", 32'(dut.en), 0);
    check("v5_period1", 32'(dut.period[1]), 0);
    check("v5_vol1", 32'(dut.vol[1]), 0);

    // Tone: voice0 period 3, vol 15 -> toggles every 4 cycles, mix 0/60.
    wr(0, 2, 8'h0F);
    wr(0, 0, 8'h03);
    wr(0, 1, 8'h00);
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(8'd60);
      exp_q.push_back(8'd0);
    end
    mon_en = 1'b1;
    wr(0, 3, 8'h01);
    repeat (26) @(posedge clk);
    #1;
    mon_en = 1'b0;
    check("tone_queue_drained", 32'(exp_q.size()), 0);
    wave0_interval("tone_interval_a");
    wave0_interval("tone_interval_b");

    // Freeze voice0 high by committing a long period just after a rising edge.
    n = 0;
    do begin pv = voice_wave[0]; @(negedge clk); n++; end
      while (!(voice_wave[0] && !pv) && n < 20);
    check("tone_rise_found", 32'(n < 20), 1);
    wr(0, 0, 8'hFF);
    wr(0, 1, 8'h0F);
    repeat (600) @(negedge clk);
    check("tone_frozen_mix", 32'(mix_level), 32'd60);
    count_high(1'b0, hi);
    check("tone_pwm_high", 32'(hi), 32'd60);

    // Reset mid-tone while output is high -> silent the next cycle.
    n = 0;
    do begin @(negedge clk); n++; end while (signal_out !== 1'b1 && n < 300);
    check("tone_out_high_before_rst", 32'(signal_out), 1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrst_signal_out", 32'(signal_out), 0);
    check("midrst_mix_level", 32'(mix_level), 0);
    check("midrst_voice_wave", 32'(voice_wave), 0);
    rst = 1'b0;

    // Atomic period on voice1.
    wr(1, 0, 8'h23);
    wr(1, 1, 8'h01);
    check("atomic_initial", 32'(dut.period[1]), 32'h123);
    wr(1, 0, 8'h45);
    repeat (100) @(posedge clk);
    #1;
    check("atomic_staged_only", 32'(dut.period[1]), 32'h123);
    wr(1, 1, 8'h06);
    check("atomic_commit", 32'(dut.period[1]), 32'h645);

    // Noise on voice2: period 0 keeps the wave low.
    wr(2, 3, 8'h03);
    any_high = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (voice_wave[2] !== 1'b0) any_high = 1'b1;
    end
    check("noise_period0_silent", 32'(any_high), 0);
    // Period 1: wave resamples LFSR bit 0 every 2 cycles.
    wr(2, 0, 8'h01);
    wr(2, 1, 8'h00);
    exp_wave = 1'b0;
    any_high = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      pre = m_lfsr[0];
      @(posedge clk);
      @(negedge clk);
      if (k % 2 == 0) exp_wave = pre;
      if (exp_wave) any_high = 1'b1;
      check("noise_wave", 32'(voice_wave[2]), 32'(exp_wave));
    end
    check("noise_saw_ones", 32'(any_high), 1);

    // Lower voice3 period 200 -> 5 at count 150: wrap on the next cycle.
    wr(3, 0, 8'hC8);
    wr(3, 1, 8'h00);
    wr(3, 3, 8'h01);
    wr(3, 0, 8'h05);
    repeat (148) @(posedge clk);
    #1;
    wr(3, 1, 8'h00);
    @(negedge clk);
    check("bnd_before_wrap", 32'(voice_wave[3]), 0);
    @(negedge clk);
    check("bnd_wrap_next", 32'(voice_wave[3]), 1);
    n = 0;
    do begin @(negedge clk); n++; end while (voice_wave[3] == 1'b1 && n < 50);
    check("bnd_new_interval", 32'(n), 32'd6);

    // Saturation: four voices at vol 15 all high.
    do_reset();
    for (int v = 0; v < 4; v++) begin
      wr(v, 2, 8'h0F);
      wr(v, 0, 8'hFF);
      wr(v, 1, 8'h0F);
    end
    exp_q.push_back(8'd60);
    exp_q.push_back(8'd120);
    exp_q.push_back(8'd180);
    exp_q.push_back(8'd240);
    mon_en = 1'b1;
    for (int v = 0; v < 4; v++) wr(v, 3, 8'h01);
    n = 0;
    do begin @(negedge clk); n++; end while (voice_wave !== 4'hF && n < 5000);
    check("sat_all_high", 32'(voice_wave), 32'hF);
    repeat (2) @(negedge clk);
    mon_en = 1'b0;
    check("sat_queue_drained", 32'(exp_q.size()), 0);
    check("sat_mix_shift2", 32'(mix_level), 32'd240);
    check("sat_mix_shift3", 32'(sat_mix_level), 32'd255);
    repeat (600) @(negedge clk);
    count_high(1'b0, hi);
    check("sat_pwm_high_240", 32'(hi), 32'd240);
    count_high(1'b1, hi);
    check("sat_pwm_low_one", 32'(256 - hi), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Watchdog against a stalled run.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/poly_signal_generator.md
Name: poly_signal_generator

Overview:
- Parametrised N-voice successor of the single-voice tone/noise generator.
- Each voice has a full-width period, volume, enable and tone/noise mode, all written over the existing strobe/address/data register bus.
- Voice outputs are summed with saturation into a PWM duty value; the block drives the 1-bit audio PWM output at the top of the audio path.
- Period writes are atomic: staged low byte, committed on the high write. This replaces the old partial-field update.

Parameters:
- N_VOICES, 4, number of voices (1..8)
- PERIOD_W, 12, tone period width in bits (9..16)
- PWM_W, 8, PWM counter / duty width
- MIX_SHIFT, 2, left shift applied to the voice sum before saturation to PWM_W
- VIDX_W, 2, voice-index width in address; must be >= clog2(N_VOICES), minimum 1

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- write_strobe  in  1  register write qualifier, sampled on posedge clk
- address  in  VIDX_W+2  {voice index, sub-register[1:0]}
- data  in  8  write data
- signal_out  out  1  PWM audio output, registered
- mix_level  out  PWM_W  current registered duty value (debug)
- voice_wave  out  N_VOICES  per-voice output bit before volume (debug)

Behaviour:
- One clock domain. rst is synchronous and active-high, and overrides write_strobe in the same cycle.
- Reset state: all periods 0, staged low byte 0, volumes 0, enables 0, modes 0, voice counters 0, voice_wave 0, LFSR 15'h0001, mix_level 0, PWM counter 0, latched duty 0, signal_out 0.
- Register write (write_strobe=1), voice v = address[VIDX_W+1:2]:
  - Writes with v >= N_VOICES are ignored.
  - sub 0: stage low byte (data[7:0]) into a per-voice holding register; the period is unchanged.
  - sub 1: period[v] <= {data[PERIOD_W-9:0], staged_low[v]}. This commit is atomic.
  - sub 2: vol[v] <= data[3:0].
  - sub 3: en[v] <= data[0]; noise_mode[v] <= data[1].
  - Every written register takes its new value at the clock edge that samples the strobe.
- Voice counter, per voice, each cycle:
  - If en=0 or period=0: counter <= 0, wave <= 0.
  - Else if counter >= period: counter <= 0 and a toggle event fires. The >= compare handles a period lowered below the current count: wrap on the next cycle.
  - Else counter <= counter+1.
  - Result: a square wave of half-period (period+1) cycles.
- Toggle event:
  - Tone mode: wave <= ~wave.
  - Noise mode: wave <= lfsr[0] (sampled value).
- LFSR: 15-bit Fibonacci, taps x^15+x^14+1, shifts every cycle: lfsr <= {lfsr[13:0], lfsr[14]^lfsr[13]}. It is shared by all voices and never reaches 0.
- Mixer (registered, 1 cycle):
  - sum = Σ(wave[v] ? vol[v] : 0), width 4+clog2(N_VOICES).
  - mix_level <= min(sum << MIX_SHIFT, 2^PWM_W-1).
- PWM:
  - pwm_cnt is free-running 0..2^PWM_W-1 and wraps.
  - Latched duty <= mix_level only when pwm_cnt == 2^PWM_W-1, giving glitch-free period updates.
  - signal_out <= (pwm_cnt < duty). Duty 0 gives a constant 0; the maximum duty gives high on 255 of 256 cycles.
- Latency from a wave edge: mix_level updates 1 cycle later. The duty applies from the next PWM period start.
- Simultaneous events:
  - A write to sub 3 clearing en in the same cycle as a toggle: the disable wins, wave <= 0.
  - A period commit in the same cycle as a wrap: the counter still wraps to 0 and the new period is used from the next cycle.
- Reset mid-operation: all state returns to its reset values on the next edge, and signal_out is 0 the cycle after rst is sampled.

Test Plan:
- Reset: hold rst 3 cycles with write_strobe=1 and random address/data → all outputs 0, registers at reset values; LFSR first values after release are 0x0002, 0x0004.
- Tone: voice0 sub0=0x03, sub1=0x00, vol=15, en=1 → voice_wave[0] toggles every 4 cycles; mix_level alternates 0/60; signal_out high 60 of 256 cycles once latched.
- Atomic period: voice1 period 0x123; write sub0=0x45 and wait 100 cycles → period still 0x123; after sub1=0x06 → period 0x645.
- Saturation: 4 voices, vol 15, all waves high, MIX_SHIFT=2 → sum 60 → mix_level 240. With MIX_SHIFT=3 → mix_level 255, and signal_out is low exactly 1 cycle per PWM period.
- Noise mode: voice2 period 0, noise_mode=1, en=1 → wave stays 0. With period 1 → wave updates every 2 cycles and matches a golden LFSR[0].
- Boundaries: lower the period from 200 to 5 at count 150 → wrap on the next cycle. A write to address voice 5 with N_VOICES=4, VIDX_W=3 → no state change. Assert rst mid-tone → silent output the next cycle.
